// File: rtl/wb_commit_unit.sv
// wb_commit_unit
//   Writeback stage of the 16-bit MIPS pipeline. It holds the MEM/WB pipeline
//   register and selects the register-file write data from one of four sources:
//   ALU, memory, link PC or immediate. The stage waits for late memory read
//   data and applies byte-load extension. It emits a one-cycle register-file
//   write strobe, which the forwarding unit also uses.
//
// Parameters
//   DATA_W       datapath width of all result sources and the write data
//   REG_ADDR_W   register-file address width
//   ZERO_REG_RO  1 = writes to register 0 are suppressed
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      MEM stage handshake
//   in_RegWrite, in_WbSel,
//   in_LoadByte, in_LoadSigned,
//   in_ALUResult, in_LinkPC,
//   in_Imm, in_DestReg       instruction fields offered by the MEM stage
//   mem_rvalid, mem_rdata    memory read data return
//   flush                    discard the held or pending instruction
//   stall_out                high while waiting for memory read data
//   out_RegWrite             one-cycle register-file write enable
//   out_WriteReg             write address
//   out_WriteData            write data
//   retire_count             (WB_RETIRE_COUNT_EN only) saturating count of real writes
//
// Build option
//   Define WB_RETIRE_COUNT_EN to add the 32-bit retire_count output.

module wb_commit_unit #(
  parameter int DATA_W      = 16,
  parameter int REG_ADDR_W  = 3,
  parameter int ZERO_REG_RO = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_RegWrite,
  input  logic [1:0]            in_WbSel,
  input  logic                  in_LoadByte,
  input  logic                  in_LoadSigned,
  input  logic [DATA_W-1:0]     in_ALUResult,
  input  logic [DATA_W-1:0]     in_LinkPC,
  input  logic [DATA_W-1:0]     in_Imm,
  input  logic [REG_ADDR_W-1:0] in_DestReg,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  flush,
  output logic                  stall_out,
`ifdef WB_RETIRE_COUNT_EN
  output logic [31:0]           retire_count,
`endif
  output logic                  out_RegWrite,
  output logic [REG_ADDR_W-1:0] out_WriteReg,
  output logic [DATA_W-1:0]     out_WriteData
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic                  accept;
  logic                  mem_pending;
  logic                  commit_load;
  logic                  accept_we;
  logic [DATA_W-1:0]     src_data;
  logic [REG_ADDR_W-1:0] commit_reg;
  logic [DATA_W-1:0]     commit_data;

  // Fields latched at accept. They are used while WAIT_MEM is waiting for
  // read data, and for the write strobe in COMMIT.
  logic                  held_we;
  logic [REG_ADDR_W-1:0] held_dest;
  logic                  held_byte;
  logic                  held_signed;

  // Byte loads replicate bit 7 (signed) or zero-fill the upper bits.
  function automatic logic [DATA_W-1:0] extend_load(
    input logic [DATA_W-1:0] raw,
    input logic              byte_ld,
    input logic              sgn
  );
    logic [DATA_W-1:0] res;
    res = raw;
    if (byte_ld) begin
      res = {{(DATA_W-8){sgn & raw[7]}}, raw[7:0]};
    end
    return res;
  endfunction

  assign accept      = in_valid & in_ready & ~flush;
  assign mem_pending = (in_WbSel == 2'b01) & ~mem_rvalid;

  // The zero-register check is done at accept. The held strobe then
  // already reflects whether the commit is a real write.
  assign accept_we = in_RegWrite &
                     ~((ZERO_REG_RO != 0) && (in_DestReg == REG_ADDR_W'(0)));

  // Result source selection for an instruction accepted this cycle.
  always_comb begin
    src_data = in_ALUResult;
    case (in_WbSel)
      2'b00:   src_data = in_ALUResult;
      2'b01:   src_data = extend_load(mem_rdata, in_LoadByte, in_LoadSigned);
      2'b10:   src_data = in_LinkPC;
      default: src_data = in_Imm;
    endcase
  end

  // A commit is loaded either from a fresh accept or from late read data.
  // Late read data is extended using the latched load flags.
  always_comb begin
    commit_load = (next_state == COMMIT);
    commit_reg  = in_DestReg;
    commit_data = src_data;
    if (state == WAIT_MEM) begin
      commit_reg  = held_dest;
      commit_data = extend_load(mem_rdata, held_byte, held_signed);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. flush overrides both accept and mem_rvalid.
  always_comb begin
    next_state = state;
    case (state)
      WAIT_MEM: begin
        if (flush) begin
          next_state = IDLE;
        end else if (mem_rvalid) begin
          next_state = COMMIT;
        end else begin
          next_state = WAIT_MEM;
        end
      end
      default: begin
        if (accept) begin
          next_state = mem_pending ? WAIT_MEM : COMMIT;
        end else begin
          next_state = IDLE;
        end
      end
    endcase
  end

  // Outputs decoded from the current state only.
  // A flush in COMMIT does not retract the strobe already on the outputs.
  always_comb begin
    in_ready     = (state != WAIT_MEM);
    stall_out    = (state == WAIT_MEM);
    out_RegWrite = (state == COMMIT) & held_we;
  end

  // Pipeline register. The write address and data change only when
  // entering COMMIT, so they hold their values between commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_we       <= 1'b0;
      held_dest     <= '0;
      held_byte     <= 1'b0;
      held_signed   <= 1'b0;
      out_WriteReg  <= '0;
      out_WriteData <= '0;
    end else begin
      if (accept) begin
        held_we     <= accept_we;
        held_dest   <= in_DestReg;
        held_byte   <= in_LoadByte;
        held_signed <= in_LoadSigned;
      end
      if (commit_load) begin
        out_WriteReg  <= commit_reg;
        out_WriteData <= commit_data;
      end
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  // Counts real register-file writes and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_count <= '0;
    end else if (out_RegWrite && (retire_count != 32'hFFFF_FFFF)) begin
      retire_count <= retire_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// tb_wb_commit_unit
//   Directed bench for wb_commit_unit with the default parameters
//   (16-bit data, 3-bit register address, register 0 read-only).
//   Single-transaction vectors come from a table. Multi-cycle cases are
//   written out by hand: late memory, back-to-back commits, flush and reset.

module tb_wb_commit_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_RegWrite;
  logic [1:0]  in_WbSel;
  logic        in_LoadByte;
  logic        in_LoadSigned;
  logic [15:0] in_ALUResult;
  logic [15:0] in_LinkPC;
  logic [15:0] in_Imm;
  logic [2:0]  in_DestReg;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        flush;
  logic        stall_out;
  logic        out_RegWrite;
  logic [2:0]  out_WriteReg;
  logic [15:0] out_WriteData;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_count;
`endif

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [1:0]  wb_sel;
    logic        load_byte;
    logic        load_signed;
    logic        reg_write;
    logic [15:0] alu;
    logic [15:0] link;
    logic [15:0] imm;
    logic [15:0] rdata;
    logic [2:0]  dest;
    logic        exp_we;
    logic [2:0]  exp_reg;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  wb_commit_unit #(
    .DATA_W     (16),
    .REG_ADDR_W (3),
    .ZERO_REG_RO(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_RegWrite  (in_RegWrite),
    .in_WbSel     (in_WbSel),
    .in_LoadByte  (in_LoadByte),
    .in_LoadSigned(in_LoadSigned),
    .in_ALUResult (in_ALUResult),
    .in_LinkPC    (in_LinkPC),
    .in_Imm       (in_Imm),
    .in_DestReg   (in_DestReg),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .flush        (flush),
    .stall_out    (stall_out),
`ifdef WB_RETIRE_COUNT_EN
    .retire_count (retire_count),
`endif
    .out_RegWrite (out_RegWrite),
    .out_WriteReg (out_WriteReg),
    .out_WriteData(out_WriteData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Drives one instruction on the MEM-stage inputs.
  task automatic applyStimulus(input logic valid, input logic [1:0] sel,
                               input logic lb, input logic ls, input logic rw,
                               input logic [15:0] alu, input logic [15:0] link,
                               input logic [15:0] imm, input logic [2:0] dest);
    in_valid      = valid;
    in_WbSel      = sel;
    in_LoadByte   = lb;
    in_LoadSigned = ls;
    in_RegWrite   = rw;
    in_ALUResult  = alu;
    in_LinkPC     = link;
    in_Imm        = imm;
    in_DestReg    = dest;
  endtask

  task automatic idle_inputs();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0;
    flush      = 1'b0;
  endtask

  initial begin
    int exp_retire;
    logic [15:0] last_data;

    tests_run    = 0;
    tests_failed = 0;

    //                 sel    lb    ls    rw    alu       link      imm       rdata     dst   we    reg   data
    vecs[0] = '{2'b00, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 16'h0000, 16'hDEAD, 3'd3, 1'b1, 3'd3, 16'h1234};
    vecs[1] = '{2'b01, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 3'd5, 1'b1, 3'd5, 16'hBEEF};
    vecs[2] = '{2'b01, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h12F0, 3'd1, 1'b1, 3'd1, 16'hFFF0};
    vecs[3] = '{2'b01, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h12F0, 3'd1, 1'b1, 3'd1, 16'h00F0};
    vecs[4] = '{2'b10, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0040, 16'h0000, 16'hDEAD, 3'd7, 1'b1, 3'd7, 16'h0040};
    vecs[5] = '{2'b11, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'hA500, 16'hDEAD, 3'd2, 1'b1, 3'd2, 16'hA500};
    vecs[6] = '{2'b00, 1'b0, 1'b0, 1'b1, 16'h5555, 16'h0000, 16'h0000, 16'hDEAD, 3'd0, 1'b0, 3'd0, 16'h5555};
    vecs[7] = '{2'b00, 1'b1, 1'b1, 1'b1, 16'h80FF, 16'h0000, 16'h0000, 16'h0080, 3'd4, 1'b1, 3'd4, 16'h80FF};
    vecs[8] = '{2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h7777, 16'hDEAD, 3'd6, 1'b0, 3'd6, 16'h7777};
    vecs[9] = '{2'b01, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'hAB7F, 3'd1, 1'b1, 3'd1, 16'h007F};

    // Reset state
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    checkOutput("reset_regwrite", 32'(out_RegWrite), 32'd0);
    checkOutput("reset_writereg", 32'(out_WriteReg), 32'd0);
    checkOutput("reset_writedata", 32'(out_WriteData), 32'd0);
    checkOutput("reset_stall", 32'(stall_out), 32'd0);
    checkOutput("reset_ready", 32'(in_ready), 32'd1);
`ifdef WB_RETIRE_COUNT_EN
    checkOutput("reset_retire", retire_count, 32'd0);
`endif
    rst = 1'b0;
    step();

    // Table vectors: accept from IDLE (memory data in the same cycle), commit, back to IDLE.
    exp_retire = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].wb_sel, vecs[i].load_byte, vecs[i].load_signed,
                    vecs[i].reg_write, vecs[i].alu, vecs[i].link, vecs[i].imm, vecs[i].dest);
      mem_rvalid = 1'b1;
      mem_rdata  = vecs[i].rdata;
      step();
      checkOutput($sformatf("vec%0d_we", i), 32'(out_RegWrite), 32'(vecs[i].exp_we));
      checkOutput($sformatf("vec%0d_reg", i), 32'(out_WriteReg), 32'(vecs[i].exp_reg));
      checkOutput($sformatf("vec%0d_data", i), 32'(out_WriteData), 32'(vecs[i].exp_data));
      if (vecs[i].exp_we) exp_retire++;
      idle_inputs();
      step();
      checkOutput($sformatf("vec%0d_we_drop", i), 32'(out_RegWrite), 32'd0);
      checkOutput($sformatf("vec%0d_data_hold", i), 32'(out_WriteData), 32'(vecs[i].exp_data));
    end
`ifdef WB_RETIRE_COUNT_EN
    checkOutput("vec_retire", retire_count, 32'(exp_retire));
`endif
    last_data = vecs[9].exp_data;

    // Late memory data: three stall cycles, with an ignored offer during the wait.
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 3'd5);
    step();
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 16'h9999, 16'h0, 16'h0, 3'd6);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("late_stall%0d", i), 32'(stall_out), 32'd1);
      checkOutput($sformatf("late_ready%0d", i), 32'(in_ready), 32'd0);
      checkOutput($sformatf("late_we%0d", i), 32'(out_RegWrite), 32'd0);
      checkOutput($sformatf("late_data_hold%0d", i), 32'(out_WriteData), 32'(last_data));
      if (i == 2) begin
        in_valid   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hBEEF;
      end
      step();
    end
    mem_rvalid = 1'b0;
    checkOutput("late_we", 32'(out_RegWrite), 32'd1);
    checkOutput("late_reg", 32'(out_WriteReg), 32'd5);
    checkOutput("late_data", 32'(out_WriteData), 32'hBEEF);
    checkOutput("late_stall_clear", 32'(stall_out), 32'd0);
    step();
    checkOutput("late_we_drop", 32'(out_RegWrite), 32'd0);

    // Back-to-back: link then immediate, then a register 0 write.
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0040, 16'h0, 3'd7);
    step();
    checkOutput("b2b_link_we", 32'(out_RegWrite), 32'd1);
    checkOutput("b2b_link_reg", 32'(out_WriteReg), 32'd7);
    checkOutput("b2b_link_data", 32'(out_WriteData), 32'h0040);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'hA500, 3'd2);
    step();
    checkOutput("b2b_imm_we", 32'(out_RegWrite), 32'd1);
    checkOutput("b2b_imm_reg", 32'(out_WriteReg), 32'd2);
    checkOutput("b2b_imm_data", 32'(out_WriteData), 32'hA500);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h0, 16'h0, 3'd0);
    step();
    checkOutput("b2b_r0_we", 32'(out_RegWrite), 32'd0);
    checkOutput("b2b_r0_data", 32'(out_WriteData), 32'h1111);
    idle_inputs();
    step();
    checkOutput("b2b_idle_we", 32'(out_RegWrite), 32'd0);

    // Flush during WAIT_MEM, even with coincident read data.
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 3'd4);
    step();
    checkOutput("flushw_stall", 32'(stall_out), 32'd1);
    in_valid   = 1'b0;
    flush      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h4444;
    step();
    flush = 1'b0;
    checkOutput("flushw_we", 32'(out_RegWrite), 32'd0);
    checkOutput("flushw_ready", 32'(in_ready), 32'd1);
    checkOutput("flushw_stall_clear", 32'(stall_out), 32'd0);
    step();
    mem_rvalid = 1'b0;
    checkOutput("flushw_stray_rvalid_we", 32'(out_RegWrite), 32'd0);
    checkOutput("flushw_data_hold", 32'(out_WriteData), 32'h1111);

    // Flush in COMMIT: current strobe survives, new offer is dropped.
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 16'h2222, 16'h0, 16'h0, 3'd1);
    step();
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h3333, 3'd2);
    flush = 1'b1;
    checkOutput("flushc_we", 32'(out_RegWrite), 32'd1);
    checkOutput("flushc_data", 32'(out_WriteData), 32'h2222);
    step();
    idle_inputs();
    checkOutput("flushc_we_next", 32'(out_RegWrite), 32'd0);
    checkOutput("flushc_data_hold", 32'(out_WriteData), 32'h2222);
    checkOutput("flushc_reg_hold", 32'(out_WriteReg), 32'd1);

    // Reset while waiting for memory.
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 3'd3);
    step();
    in_valid = 1'b0;
    checkOutput("rstw_stall", 32'(stall_out), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rstw_we", 32'(out_RegWrite), 32'd0);
    checkOutput("rstw_reg", 32'(out_WriteReg), 32'd0);
    checkOutput("rstw_data", 32'(out_WriteData), 32'd0);
    checkOutput("rstw_stall_clear", 32'(stall_out), 32'd0);
    checkOutput("rstw_ready", 32'(in_ready), 32'd1);
`ifdef WB_RETIRE_COUNT_EN
    checkOutput("rstw_retire", retire_count, 32'd0);
`endif
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h5A5A;
    step();
    mem_rvalid = 1'b0;
    checkOutput("rstw_late_rvalid_we", 32'(out_RegWrite), 32'd0);
    checkOutput("rstw_late_rvalid_data", 32'(out_WriteData), 32'd0);

`ifdef WB_RETIRE_COUNT_EN
    // One real write bumps the counter. A register 0 write does not.
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0101, 16'h0, 16'h0, 3'd1);
    step();
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0202, 16'h0, 16'h0, 3'd0);
    step();
    idle_inputs();
    checkOutput("retire_one", retire_count, 32'd1);
    step();
    checkOutput("retire_r0_skip", retire_count, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Parametrised successor to the single 2:1 writeback mux of the 16-bit MIPS pipeline.
- Holds the MEM/WB pipeline register and chooses one of four result sources: ALU, memory, link PC or immediate.
- Waits for late memory read data and applies byte-load extension.
- Produces a one-cycle register-file write strobe that also feeds the forwarding unit.

Parameters:
- DATA_W, 16, datapath width of all result sources and the write data.
- REG_ADDR_W, 3, register-file address width.
- ZERO_REG_RO, 1, when 1, writes to register 0 are suppressed.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  MEM stage offers an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_RegWrite  input  1  instruction writes the register file.
- in_WbSel  input  2  00 ALU, 01 memory, 10 link PC, 11 immediate.
- in_LoadByte  input  1  memory source uses the low byte only.
- in_LoadSigned  input  1  byte load is sign-extended (0 means zero-extend).
- in_ALUResult  input  DATA_W  ALU result.
- in_LinkPC  input  DATA_W  return address.
- in_Imm  input  DATA_W  immediate or LUI value.
- in_DestReg  input  REG_ADDR_W  destination register.
- mem_rvalid  input  1  read data valid strobe.
- mem_rdata  input  DATA_W  read data.
- flush  input  1  discard the held or pending instruction.
- stall_out  output  1  high while waiting for memory.
- out_RegWrite  output  1  register-file write enable, one-cycle pulse.
- out_WriteReg  output  REG_ADDR_W  write address.
- out_WriteData  output  DATA_W  write data.

Behaviour:
- States: IDLE, WAIT_MEM, COMMIT.
- Reset: state IDLE. out_RegWrite, out_WriteReg, out_WriteData and stall_out are 0. in_ready is 1.
- in_ready is 1 in IDLE and COMMIT, and 0 in WAIT_MEM. Accept = in_valid & in_ready & !flush.
- Accept with in_WbSel != 01, or with 01 and mem_rvalid in the same cycle:
  - Source is selected and registered; next state is COMMIT.
  - Latency is 1 cycle: out_RegWrite is high in the cycle after accept.
- Accept with in_WbSel == 01 and no mem_rvalid:
  - Destination and control fields are latched; next state is WAIT_MEM.
  - stall_out is high, combinationally, for the whole time the state is WAIT_MEM.
- In WAIT_MEM, mem_rvalid captures and extends mem_rdata and moves to COMMIT. The write happens 1 cycle after mem_rvalid.
- COMMIT lasts exactly one cycle, with out_RegWrite = held RegWrite.
  - A new accept in COMMIT goes to COMMIT or WAIT_MEM, so back-to-back commits occur every cycle.
  - With no accept, the next state is IDLE.
- out_RegWrite is 0 in IDLE and WAIT_MEM.
- out_WriteReg and out_WriteData hold their last values when not committing.
- Byte extension:
  - LoadByte=1: data = {DATA_W-8 copies of mem_rdata[7] if LoadSigned else 0, mem_rdata[7:0]}.
  - LoadByte=0: data = mem_rdata unchanged.
  - LoadByte is ignored for non-memory sources.
- ZERO_REG_RO=1 and held DestReg == 0: out_RegWrite is forced to 0 in COMMIT. Data and address still update.
- flush has priority over accept and over mem_rvalid. Next state is IDLE, no write occurs, and out_RegWrite is 0 in the next cycle.
  - A flush during COMMIT does not cancel the write already on the outputs that cycle.
- mem_rvalid outside WAIT_MEM, and not coincident with a memory accept, is ignored.
- rst asserted in WAIT_MEM returns to IDLE; the pending write is lost.
- in_WbSel is decoded fully; no illegal encodings exist.

Optional Feature:
- Macro WB_RETIRE_COUNT_EN.
- When defined, adds output retire_count (32 bits).
  - It increments on every COMMIT cycle where out_RegWrite=1, clears on rst, and saturates at 0xFFFFFFFF.
- When not defined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then ALU source: accept ALUResult=0x1234, DestReg=3 -> next cycle out_RegWrite=1, WriteReg=3, WriteData=0x1234; the following cycle out_RegWrite=0.
- Memory load, late data: accept WbSel=01, DestReg=5; mem_rvalid 3 cycles later with 0xBEEF -> stall_out and in_ready=0 for those 3 cycles; write of 0xBEEF one cycle after rvalid.
- Byte loads: mem_rdata=0x12F0 with LoadByte=1 -> LoadSigned=1 writes 0xFFF0; LoadSigned=0 writes 0x00F0.
- Back-to-back: link (LinkPC=0x0040, reg 7) then Imm=0xA500 (reg 2) on consecutive cycles -> two consecutive write pulses with the correct values; reg 0 destination gives no write pulse.
- Flush during WAIT_MEM, followed by mem_rvalid -> no write pulse, state IDLE, in_ready=1.
- rst asserted mid-WAIT_MEM -> all outputs 0 next cycle; with WB_RETIRE_COUNT_EN defined, retire_count=0 and it increments by 1 per real write.
